// File: rtl/serv_ibus_rsp_if.sv
// Instruction-bus response port bundle: fetch request/response plus the memory load port.
// Latency: none (wiring only).
// Backpressure: none; the initiator holds i_ibus_cyc until it sees o_ibus_ack or o_ibus_err.
//
// Signal names follow the responder's point of view (i_ = into the responder, o_ = out of it).
//   i_ibus_adr  [31:0]   fetch byte address
//   i_ibus_cyc           fetch request, held until acknowledged
//   o_ibus_rdt  [31:0]   instruction word, zero whenever no strobe is high
//   o_ibus_ack           one-cycle response strobe
//   o_ibus_err           one-cycle error strobe (replaces ack)
//   i_ld_we              memory load write enable
//   i_ld_adr    [AW-1:0] memory load word index
//   i_ld_dat    [31:0]   memory load data
interface serv_ibus_rsp_if #(
  parameter int AW = 8
);

  logic [31:0]   i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;
  logic          o_ibus_err;
  logic          i_ld_we;
  logic [AW-1:0] i_ld_adr;
  logic [31:0]   i_ld_dat;

  // Core / loader side.
  modport master (
    output i_ibus_adr,
    output i_ibus_cyc,
    output i_ld_we,
    output i_ld_adr,
    output i_ld_dat,
    input  o_ibus_rdt,
    input  o_ibus_ack,
    input  o_ibus_err
  );

  // Memory responder side.
  modport slave (
    input  i_ibus_adr,
    input  i_ibus_cyc,
    input  i_ld_we,
    input  i_ld_adr,
    input  i_ld_dat,
    output o_ibus_rdt,
    output o_ibus_ack,
    output o_ibus_err
  );

endinterface

// File: rtl/serv_ibus_rsp.sv
// Instruction memory responder for a SERV-style ibus: latches a fetch, waits, then strobes ack or err.
// Latency: WAIT_STATES+1 cycles from the edge sampling i_ibus_cyc in IDLE (1 cycle on a prefetch hit).
// Backpressure: none; dropping i_ibus_cyc during the wait aborts the fetch with no strobe.
//
// Ports:
//   clk      sole clock, rising edge
//   i_rst_n  asynchronous active-low reset (clears FSM and outputs, not the memory)
//   bus      serv_ibus_rsp_if.slave: fetch request/response and memory load port
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles before each response (0..15)
// Build option:
//   SERV_IBUS_PREFETCH_EN  adds a one-word sequential prefetch buffer (next index after each ack).
module serv_ibus_rsp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  serv_ibus_rsp_if.slave       bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:2]   r_adr;      // byte offset bits are never used, so never stored
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdt;
  logic [31:0]   r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_idx;       // word index of the latched fetch
  logic          w_oor;       // latched fetch lies outside the memory
  logic [AW-1:0] w_req_idx;   // word index of the incoming request
  logic          w_req_ok;    // incoming request lies inside the memory
  logic          w_unused;

  assign w_idx     = r_adr[AW+1:2];
  assign w_oor     = |r_adr[31:AW+2];
  assign w_req_idx = bus.i_ibus_adr[AW+1:2];
  assign w_req_ok  = ~|bus.i_ibus_adr[31:AW+2];
  assign w_unused  = &{1'b0, bus.i_ibus_adr[1:0]};

  // ---------------------------------------------------------------------------
  // Instruction memory: write port only, never reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (bus.i_ld_we) begin
      r_mem[bus.i_ld_adr] <= bus.i_ld_dat;
    end
  end

`ifdef SERV_IBUS_PREFETCH_EN
  // ---------------------------------------------------------------------------
  // Prefetch buffer: after every ack the next sequential word is fetched,
  // taking the same WAIT_STATES the core would otherwise spend waiting.
  // ---------------------------------------------------------------------------
  logic          r_pf_vld;
  logic          r_pf_fill;
  logic [3:0]    r_pf_cnt;
  logic [AW-1:0] r_pf_tag;
  logic [31:0]   r_pf_dat;
  logic          r_hit;      // current RESP is served from the buffer
  logic [AW-1:0] w_nxt_idx;
  logic          w_pf_hit;
  logic          w_pf_fmatch;

  assign w_nxt_idx   = w_idx + AW'(1);   // wraps modulo DEPTH
  // A load landing on the same edge as the hit check would make the buffer
  // stale before RESP reads it, so such a request falls back to the memory.
  assign w_pf_hit    = r_pf_vld && !bus.i_ld_we && w_req_ok && (r_pf_tag == w_req_idx);
  assign w_pf_fmatch = r_pf_fill && w_req_ok && (r_pf_tag == w_req_idx);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pf_vld  <= 1'b0;
      r_pf_fill <= 1'b0;
      r_pf_cnt  <= 4'd0;
      r_pf_tag  <= '0;
      r_pf_dat  <= 32'd0;
    end else if (bus.i_ld_we) begin
      // Any memory write may alias the buffered word.
      r_pf_vld  <= 1'b0;
      r_pf_fill <= 1'b0;
    end else if ((r_state == S_RESP) && w_oor) begin
      r_pf_vld  <= 1'b0;
      r_pf_fill <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_pf_tag <= w_nxt_idx;
      if (WAIT_STATES == 0) begin
        r_pf_vld  <= 1'b1;
        r_pf_fill <= 1'b0;
        r_pf_dat  <= r_mem[w_nxt_idx];
      end else begin
        r_pf_vld  <= 1'b0;
        r_pf_fill <= 1'b1;
        r_pf_cnt  <= WS_M1;
      end
    end else if (r_pf_fill) begin
      if (r_pf_cnt == 4'd0) begin
        r_pf_vld  <= 1'b1;
        r_pf_fill <= 1'b0;
        r_pf_dat  <= r_mem[r_pf_tag];
      end else begin
        r_pf_cnt <= r_pf_cnt - 4'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered strobes and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_adr   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdt   <= 32'd0;
`ifdef SERV_IBUS_PREFETCH_EN
      r_hit   <= 1'b0;
`endif
    end else begin
      // Strobes last exactly one cycle; read data is zero outside a strobe.
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rdt <= 32'd0;

      case (r_state)
        S_IDLE: begin
          if (bus.i_ibus_cyc) begin
            r_adr <= bus.i_ibus_adr[31:2];
`ifdef SERV_IBUS_PREFETCH_EN
            r_hit <= w_pf_hit;
            if (w_pf_hit) begin
              r_state <= S_RESP;
              r_cnt   <= 4'd0;
            end else if (w_pf_fmatch) begin
              // The fill completes r_pf_cnt edges from now; wait only that long.
              if (r_pf_cnt == 4'd0) begin
                r_state <= S_RESP;
              end else begin
                r_state <= S_WAIT;
                r_cnt   <= r_pf_cnt - 4'd1;
              end
            end else
`endif
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WS_M1;
            end else begin
              r_state <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          if (!bus.i_ibus_cyc) begin
            // Initiator withdrew the request: abort silently.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_RESP: begin
          // The memory read happens on this edge, so a load on the same
          // edge is not yet visible and the old word is returned.
          r_state <= S_IDLE;
          if (w_oor) begin
            r_err <= 1'b1;
          end else begin
            r_ack <= 1'b1;
`ifdef SERV_IBUS_PREFETCH_EN
            r_rdt <= r_hit ? r_pf_dat : r_mem[w_idx];
`else
            r_rdt <= r_mem[w_idx];
`endif
          end
`ifdef SERV_IBUS_PREFETCH_EN
          r_hit <= 1'b0;
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.o_ibus_ack = r_ack;
  assign bus.o_ibus_err = r_err;
  assign bus.o_ibus_rdt = r_rdt;

endmodule

// File: tb/tb_serv_ibus_rsp.sv
// Directed bench for serv_ibus_rsp: several instances with different WAIT_STATES share clock and reset.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_serv_ibus_rsp;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nfail;

  serv_ibus_rsp_if #(.AW(8)) if0 ();
  serv_ibus_rsp_if #(.AW(8)) if2 ();
  serv_ibus_rsp_if #(.AW(8)) if3 ();

  serv_ibus_rsp #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (.clk(clk), .i_rst_n(rst_n), .bus(if0));
  serv_ibus_rsp #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (.clk(clk), .i_rst_n(rst_n), .bus(if2));
  serv_ibus_rsp #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (.clk(clk), .i_rst_n(rst_n), .bus(if3));

`ifdef SERV_IBUS_PREFETCH_EN
  serv_ibus_rsp_if #(.AW(8)) if4 ();
  serv_ibus_rsp #(.DEPTH(256), .WAIT_STATES(4)) u_pf4 (.clk(clk), .i_rst_n(rst_n), .bus(if4));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic cyc, input logic [31:0] adr);
    case (sel)
      0: begin if0.i_ibus_cyc = cyc; if0.i_ibus_adr = adr; end
      2: begin if2.i_ibus_cyc = cyc; if2.i_ibus_adr = adr; end
      3: begin if3.i_ibus_cyc = cyc; if3.i_ibus_adr = adr; end
`ifdef SERV_IBUS_PREFETCH_EN
      4: begin if4.i_ibus_cyc = cyc; if4.i_ibus_adr = adr; end
`endif
      default: ;
    endcase
  endtask

  task automatic set_ld(input int sel, input logic we, input logic [7:0] idx, input logic [31:0] dat);
    case (sel)
      0: begin if0.i_ld_we = we; if0.i_ld_adr = idx; if0.i_ld_dat = dat; end
      2: begin if2.i_ld_we = we; if2.i_ld_adr = idx; if2.i_ld_dat = dat; end
      3: begin if3.i_ld_we = we; if3.i_ld_adr = idx; if3.i_ld_dat = dat; end
`ifdef SERV_IBUS_PREFETCH_EN
      4: begin if4.i_ld_we = we; if4.i_ld_adr = idx; if4.i_ld_dat = dat; end
`endif
      default: ;
    endcase
  endtask

  function automatic logic get_ack(input int sel);
    case (sel)
      0: return if0.o_ibus_ack;
      2: return if2.o_ibus_ack;
      3: return if3.o_ibus_ack;
`ifdef SERV_IBUS_PREFETCH_EN
      4: return if4.o_ibus_ack;
`endif
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      0: return if0.o_ibus_err;
      2: return if2.o_ibus_err;
      3: return if3.o_ibus_err;
`ifdef SERV_IBUS_PREFETCH_EN
      4: return if4.o_ibus_err;
`endif
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic [31:0] get_rdt(input int sel);
    case (sel)
      0: return if0.o_ibus_rdt;
      2: return if2.o_ibus_rdt;
      3: return if3.o_ibus_rdt;
`ifdef SERV_IBUS_PREFETCH_EN
      4: return if4.o_ibus_rdt;
`endif
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  function automatic logic strb(input int sel);
    return get_ack(sel) | get_err(sel);
  endfunction

  task automatic load(input int sel, input logic [7:0] idx, input logic [31:0] dat);
    set_ld(sel, 1'b1, idx, dat);
    step(1);
    set_ld(sel, 1'b0, 8'd0, 32'd0);
  endtask

  // Full fetch: measures edges from the sampling edge to the strobe, checks
  // the strobe and data, drops cyc and checks everything clears next cycle.
  task automatic fetch(input int sel, input logic [31:0] adr, input int lat,
                       input logic exp_err, input logic [31:0] exp_rdt, input string tag);
    int n;
    drive(sel, 1'b1, adr);
    step(1);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!strb(sel) && n < 40);
    check($sformatf("%s_lat", tag), 32'(n), 32'(lat));
    check($sformatf("%s_ack", tag), {31'd0, get_ack(sel)}, {31'd0, ~exp_err});
    check($sformatf("%s_err", tag), {31'd0, get_err(sel)}, {31'd0, exp_err});
    check($sformatf("%s_rdt", tag), get_rdt(sel), exp_rdt);
    drive(sel, 1'b0, 32'd0);
    step(1);
    check($sformatf("%s_strb_clr", tag), {31'd0, strb(sel)}, 32'd0);
    check($sformatf("%s_rdt_clr", tag), get_rdt(sel), 32'd0);
  endtask

  task automatic watch(input int sel, input int cycles, input string tag);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      step(1);
      if (strb(sel)) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 32'd0); set_ld(0, 1'b0, 8'd0, 32'd0);
    drive(2, 1'b0, 32'd0); set_ld(2, 1'b0, 8'd0, 32'd0);
    drive(3, 1'b0, 32'd0); set_ld(3, 1'b0, 8'd0, 32'd0);
`ifdef SERV_IBUS_PREFETCH_EN
    drive(4, 1'b0, 32'd0); set_ld(4, 1'b0, 8'd0, 32'd0);
`endif
    #12;
    check("rst_ack", {31'd0, if2.o_ibus_ack}, 32'd0);
    check("rst_err", {31'd0, if2.o_ibus_err}, 32'd0);
    check("rst_rdt", if2.o_ibus_rdt, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Basic fetch, byte offset ignored, out-of-range error.
    load(2, 8'd5, 32'h00500093);
    fetch(2, 32'h0000_0014, 3, 1'b0, 32'h00500093, "ws2_fetch14");
    fetch(2, 32'h0000_0017, 3, 1'b0, 32'h00500093, "ws2_fetch17");
    fetch(2, 32'h0000_0400, 3, 1'b1, 32'd0, "ws2_err400");

    // Abort during WAIT, then a clean fetch.
    load(3, 8'd0, 32'h11112222);
    drive(3, 1'b1, 32'd0);
    step(2);
    drive(3, 1'b0, 32'd0);
    watch(3, 6, "ws3_abort_quiet");
    fetch(3, 32'h0000_0000, 4, 1'b0, 32'h11112222, "ws3_after_abort");

    // Load during WAIT is visible; load on the RESP edge is not.
    load(2, 8'd3, 32'h0BADF00D);
    drive(2, 1'b1, 32'h0000_000C);
    step(1);
    set_ld(2, 1'b1, 8'd3, 32'hDEADBEEF);
    step(1);
    set_ld(2, 1'b0, 8'd0, 32'd0);
    step(2);
    check("ld_wait_ack", {31'd0, if2.o_ibus_ack}, 32'd1);
    check("ld_wait_rdt", if2.o_ibus_rdt, 32'hDEADBEEF);
    drive(2, 1'b0, 32'd0);
    step(1);
    drive(2, 1'b1, 32'h0000_000C);
    step(3);
    set_ld(2, 1'b1, 8'd3, 32'h12345678);
    step(1);
    set_ld(2, 1'b0, 8'd0, 32'd0);
    check("ld_resp_ack", {31'd0, if2.o_ibus_ack}, 32'd1);
    check("ld_resp_rdt_old", if2.o_ibus_rdt, 32'hDEADBEEF);
    drive(2, 1'b0, 32'd0);
    step(1);
    fetch(2, 32'h0000_000C, 3, 1'b0, 32'h12345678, "ld_resp_new");

    // Zero wait states: latency 1, back-to-back, index wrap, high-bit error.
    load(0, 8'd1, 32'h00001111);
    load(0, 8'd2, 32'h22220000);
    drive(0, 1'b1, 32'h0000_0004);
    step(2);
    check("b2b_ack1", {31'd0, if0.o_ibus_ack}, 32'd1);
    check("b2b_rdt1", if0.o_ibus_rdt, 32'h00001111);
    drive(0, 1'b1, 32'h0000_0008);
    step(1);
    check("b2b_gap", {31'd0, strb(0)}, 32'd0);
    step(1);
    check("b2b_ack2", {31'd0, if0.o_ibus_ack}, 32'd1);
    check("b2b_rdt2", if0.o_ibus_rdt, 32'h22220000);
    drive(0, 1'b0, 32'd0);
    step(1);
    check("b2b_end", {31'd0, strb(0)}, 32'd0);
    load(0, 8'd255, 32'hFFFF0001);
    fetch(0, 32'h0000_03FF, 1, 1'b0, 32'hFFFF0001, "ws0_top");
    fetch(0, 32'hFFFF_FFFC, 1, 1'b1, 32'd0, "ws0_hi_err");

    // Reset while ack is high clears outputs immediately.
    load(0, 8'd7, 32'h00000077);
    drive(0, 1'b1, 32'h0000_001C);
    step(2);
    check("rst_ack_pre", {31'd0, if0.o_ibus_ack}, 32'd1);
    drive(0, 1'b0, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ack_now", {31'd0, if0.o_ibus_ack}, 32'd0);
    check("rst_rdt_now", if0.o_ibus_rdt, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Reset mid-WAIT and in RESP discards the fetch.
    load(2, 8'd6, 32'hA5A5A5A5);
    drive(2, 1'b1, 32'h0000_0018);
    step(2);
    rst_n = 1'b0;
    drive(2, 1'b0, 32'd0);
    #1;
    check("rstw_ack", {31'd0, if2.o_ibus_ack}, 32'd0);
    check("rstw_err", {31'd0, if2.o_ibus_err}, 32'd0);
    check("rstw_rdt", if2.o_ibus_rdt, 32'd0);
    step(1);
    rst_n = 1'b1;
    watch(2, 5, "rstw_quiet");
    drive(2, 1'b1, 32'h0000_0018);
    step(3);
    rst_n = 1'b0;
    drive(2, 1'b0, 32'd0);
    step(1);
    rst_n = 1'b1;
    watch(2, 5, "rstr_quiet");
    fetch(2, 32'h0000_0018, 3, 1'b0, 32'hA5A5A5A5, "post_rst");

`ifdef SERV_IBUS_PREFETCH_EN
    // Sequential prefetch hit, then invalidation by a load.
    load(4, 8'd8,  32'h00000808);
    load(4, 8'd9,  32'h00000909);
    load(4, 8'd10, 32'h00000A0A);
    fetch(4, 32'h0000_0020, 5, 1'b0, 32'h00000808, "pf_first");
    step(4);
    fetch(4, 32'h0000_0024, 1, 1'b0, 32'h00000909, "pf_hit");
    load(4, 8'd10, 32'hCAFE0010);
    fetch(4, 32'h0000_0028, 5, 1'b0, 32'hCAFE0010, "pf_inval");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
